// File: rtl/priority_decoder_tracker.sv
// Per-line status tracker with a binary-to-one-hot decoder.
// Single-line SET/CLEAR commands, plus a SWEEP that clears every line in index order.
module priority_decoder_tracker #(
    parameter int OUTPUT_SIZE = 8
) (
    input  logic                            clock_i,
    input  logic                            resetn_i,
    input  logic                            req_i,
    input  logic [1:0]                      req_op_i,
    input  logic [$clog2(OUTPUT_SIZE)-1:0]  req_index_i,
    output logic                            ready_o,
    output logic [OUTPUT_SIZE-1:0]          onehot_o,
    output logic                            strobe_o,
    output logic [OUTPUT_SIZE-1:0]          status_o,
    output logic [$clog2(OUTPUT_SIZE):0]    count_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic                            done_o
);

    localparam int BW = $clog2(OUTPUT_SIZE);
    localparam logic [BW:0] SIZE_W  = (BW+1)'(OUTPUT_SIZE);
    localparam logic [BW:0] ONE_W   = {{BW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_r, state_n;
    // One bit wider than an index: the value OUTPUT_SIZE marks "all lines swept".
    logic [BW:0]            ptr_r, ptr_n;
    logic [OUTPUT_SIZE-1:0] onehot_r, onehot_n;
    logic                   strobe_r, strobe_n;
    logic [OUTPUT_SIZE-1:0] status_r, status_n;
    logic [BW:0]            count_r, count_n;
    logic                   idx_valid_s;
    logic [BW-1:0]          sweep_idx_s;

    function automatic logic [OUTPUT_SIZE-1:0] decode(input logic [BW-1:0] idx);
        logic [OUTPUT_SIZE-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    assign idx_valid_s = ({1'b0, req_index_i} < SIZE_W);
    assign sweep_idx_s = ptr_r[BW-1:0];

    // Next-state and next-output computation for the command FSM.
    always_comb begin
        state_n  = state_r;
        ptr_n    = ptr_r;
        onehot_n = onehot_r;
        strobe_n = 1'b0;
        status_n = status_r;
        count_n  = count_r;
        case (state_r)
            IDLE: begin
                if (req_i) begin
                    case (req_op_i)
                        2'b00: begin
                            if (idx_valid_s) begin
                                onehot_n = decode(req_index_i);
                                strobe_n = 1'b1;
                                if (!status_r[req_index_i]) begin
                                    status_n[req_index_i] = 1'b1;
                                    count_n = count_r + ONE_W;
                                end else begin
                                    count_n = count_r;
                                end
                            end else begin
                                strobe_n = 1'b0;
                            end
                        end
                        2'b01: begin
                            if (idx_valid_s) begin
                                onehot_n = decode(req_index_i);
                                strobe_n = 1'b1;
                                if (status_r[req_index_i]) begin
                                    status_n[req_index_i] = 1'b0;
                                    count_n = count_r - ONE_W;
                                end else begin
                                    count_n = count_r;
                                end
                            end else begin
                                strobe_n = 1'b0;
                            end
                        end
                        2'b10: begin
                            state_n = SWEEP;
                            ptr_n   = '0;
                        end
                        default: begin
                            strobe_n = 1'b0;
                        end
                    endcase
                end else begin
                    strobe_n = 1'b0;
                end
            end
            SWEEP: begin
                if (ptr_r < SIZE_W) begin
                    onehot_n = decode(sweep_idx_s);
                    strobe_n = 1'b1;
                    ptr_n    = ptr_r + ONE_W;
                    if (status_r[sweep_idx_s]) begin
                        status_n[sweep_idx_s] = 1'b0;
                        count_n = count_r - ONE_W;
                    end else begin
                        count_n = count_r;
                    end
                end else begin
                    state_n = DONE;
                    ptr_n   = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            onehot_r <= '0;
            strobe_r <= 1'b0;
            status_r <= '0;
            count_r  <= '0;
        end else begin
            state_r  <= state_n;
            ptr_r    <= ptr_n;
            onehot_r <= onehot_n;
            strobe_r <= strobe_n;
            status_r <= status_n;
            count_r  <= count_n;
        end
    end

    assign ready_o  = (state_r == IDLE);
    assign done_o   = (state_r == DONE);
    assign onehot_o = onehot_r;
    assign strobe_o = strobe_r;
    assign status_o = status_r;
    assign count_o  = count_r;
    assign full_o   = (count_r == SIZE_W);
    assign empty_o  = (count_r == '0);

endmodule

// File: tb/tb_priority_decoder_tracker.sv
// Directed bench for priority_decoder_tracker (OUTPUT_SIZE=8): expectations are queued
// as stimulus is driven and compared after the following clock edge.
module tb_priority_decoder_tracker;

    logic       clk;
    logic       resetn;
    logic       req;
    logic [1:0] op;
    logic [2:0] idx;
    logic       ready_o, strobe_o, full_o, empty_o, done_o;
    logic [7:0] onehot_o, status_o;
    logic [3:0] count_o;

    typedef struct {
        string      tag;
        logic       ready;
        logic       strobe;
        logic       done;
        logic [7:0] onehot;
        logic [7:0] status;
        logic [3:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] st;

    priority_decoder_tracker #(.OUTPUT_SIZE(8)) dut (
        .clock_i     (clk),
        .resetn_i    (resetn),
        .req_i       (req),
        .req_op_i    (op),
        .req_index_i (idx),
        .ready_o     (ready_o),
        .onehot_o    (onehot_o),
        .strobe_o    (strobe_o),
        .status_o    (status_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .done_o      (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic rdy, input logic stb, input logic dn,
                            input logic [7:0] oh, input logic [7:0] stat, input logic [3:0] cnt);
        exp_t e;
        e.tag = tag; e.ready = rdy; e.strobe = stb; e.done = dn;
        e.onehot = oh; e.status = stat; e.count = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "ready",  32'(ready_o),  32'(e.ready));
        chk(e.tag, "strobe", 32'(strobe_o), 32'(e.strobe));
        chk(e.tag, "done",   32'(done_o),   32'(e.done));
        chk(e.tag, "onehot", 32'(onehot_o), 32'(e.onehot));
        chk(e.tag, "status", 32'(status_o), 32'(e.status));
        chk(e.tag, "count",  32'(count_o),  32'(e.count));
        chk(e.tag, "full",   32'(full_o),   32'(e.count == 4'd8));
        chk(e.tag, "empty",  32'(empty_o),  32'(e.count == 4'd0));
    endtask

    task automatic cyc(input logic r, input logic [1:0] o, input logic [2:0] i);
        req = r; op = o; idx = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; op = 2'b00; idx = 3'd0;
        #2;
        push_exp("reset", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        pop_check();
        @(negedge clk) resetn = 1'b1;

        // Single SET, then an idle cycle where onehot holds and strobe drops
        push_exp("set3", 1'b1, 1'b1, 1'b0, 8'h08, 8'h08, 4'd1);
        cyc(1'b1, 2'b00, 3'd3); pop_check();
        push_exp("hold", 1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 4'd1);
        cyc(1'b0, 2'b00, 3'd0); pop_check();

        // SET every line back to back, then a repeat SET
        st = 8'h08;
        for (int i = 0; i < 8; i++) begin
            st = st | (8'h01 << i);
            push_exp($sformatf("setall%0d", i), 1'b1, 1'b1, 1'b0, 8'h01 << i, st, 4'($countones(st)));
            cyc(1'b1, 2'b00, 3'(i)); pop_check();
        end
        push_exp("reset5", 1'b1, 1'b1, 1'b0, 8'h20, 8'hFF, 4'd8);
        cyc(1'b1, 2'b00, 3'd5); pop_check();

        // CLEAR down to A5
        for (int i = 1; i < 8; i++) begin
            if (i == 1 || i == 3 || i == 4 || i == 6) begin
                st = st & ~(8'h01 << i);
                push_exp($sformatf("clr%0d", i), 1'b1, 1'b1, 1'b0, 8'h01 << i, st, 4'($countones(st)));
                cyc(1'b1, 2'b01, 3'(i)); pop_check();
            end
        end

        // SWEEP from A5 with a SET idx 1 held throughout
        push_exp("sweep_acc", 1'b0, 1'b0, 1'b0, 8'h40, 8'hA5, 4'd4);
        cyc(1'b1, 2'b10, 3'd0); pop_check();
        for (int k = 0; k < 8; k++) begin
            st = st & ~(8'h01 << k);
            push_exp($sformatf("sweep%0d", k), 1'b0, 1'b1, 1'b0, 8'h01 << k, st, 4'($countones(st)));
            cyc(1'b1, 2'b00, 3'd1); pop_check();
        end
        push_exp("sweep_done", 1'b0, 1'b0, 1'b1, 8'h80, 8'h00, 4'd0);
        cyc(1'b1, 2'b00, 3'd1); pop_check();
        push_exp("sweep_ready", 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 4'd0);
        cyc(1'b1, 2'b00, 3'd1); pop_check();
        push_exp("held_set1", 1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 4'd1);
        cyc(1'b1, 2'b00, 3'd1); pop_check();

        // CLEAR of already-clear line still strobes; reserved op does nothing
        push_exp("clr1", 1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 4'd0);
        cyc(1'b1, 2'b01, 3'd1); pop_check();
        push_exp("clr2_empty", 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 4'd0);
        cyc(1'b1, 2'b01, 3'd2); pop_check();
        push_exp("op11", 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 4'd0);
        cyc(1'b1, 2'b11, 3'd6); pop_check();

        // Reset in the middle of a sweep
        push_exp("set6", 1'b1, 1'b1, 1'b0, 8'h40, 8'h40, 4'd1);
        cyc(1'b1, 2'b00, 3'd6); pop_check();
        push_exp("sw2_acc", 1'b0, 1'b0, 1'b0, 8'h40, 8'h40, 4'd1);
        cyc(1'b1, 2'b10, 3'd0); pop_check();
        push_exp("sw2_s0", 1'b0, 1'b1, 1'b0, 8'h01, 8'h40, 4'd1);
        cyc(1'b0, 2'b00, 3'd0); pop_check();
        push_exp("sw2_s1", 1'b0, 1'b1, 1'b0, 8'h02, 8'h40, 4'd1);
        cyc(1'b0, 2'b00, 3'd0); pop_check();
        #2 resetn = 1'b0;
        #1;
        push_exp("async_rst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        pop_check();
        push_exp("in_rst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        cyc(1'b0, 2'b00, 3'd0); pop_check();
        @(negedge clk) resetn = 1'b1;
        push_exp("post_rst", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        cyc(1'b0, 2'b00, 3'd0); pop_check();
        push_exp("post_rst2", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        cyc(1'b0, 2'b00, 3'd0); pop_check();
        push_exp("set7", 1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 4'd1);
        cyc(1'b1, 2'b00, 3'd7); pop_check();
        req = 1'b0;

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
